button_irq_sequencer: RTL

BUTTON_IRQ_SEQUENCER -- requirements
Module: button_irq_sequencer

---
 rtl/button_irq_sequencer.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/button_irq_sequencer.sv
// Button interrupt sequencer: services PIO edge captures round-robin and queues
// one event word per serviced press for the CPU to read.

// Generic synchronous FIFO with valid/ready on both sides.
// Latency: a written word is visible on rd_dat the cycle after the write.
// Backpressure: wr_rdy drops when full unless a read is accepted in the same cycle.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    output logic                     wr_rdy,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    input  logic                     rd_rdy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign rd_vld  = (count_q != '0);
    assign rd_dat  = mem_q[rd_ptr_q];
    assign do_pop  = rd_rdy && rd_vld;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_rdy  = (count_q != (AW+1)'(DEPTH)) || do_pop;
    assign do_push = wr_vld && wr_rdy;
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// Round-robin button PIO service sequencer with CPU-visible event FIFO.
// Latency: eligible irq in IDLE to event in FIFO is 4 cycles; CPU reads return 1 cycle later.
// Backpressure: none upstream; a push into a full FIFO is dropped and flagged as OVERFLOW.
module button_irq_sequencer #(
    parameter int N_SRC      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_SRC-1:0]      src_irq,
    output logic [N_SRC-1:0]      m_chipselect,
    output logic [1:0]            m_address,
    output logic                  m_write_n,
    output logic [31:0]           m_writedata,
    input  logic [32*N_SRC-1:0]   m_readdata,
    input  logic                  s_chipselect,
    input  logic [1:0]            s_address,
    input  logic                  s_read,
    input  logic                  s_write,
    input  logic [31:0]           s_writedata,
    output logic [31:0]           s_readdata,
    output logic                  irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, READ, WAIT, CLEAR, PUSH} state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [7:0]         seq_q, seq_d;
    logic               ovf_q, ovf_d;
    logic [N_SRC-1:0]   enable_q, enable_d;
    logic [31:0]        s_readdata_q, s_readdata_d;

    logic [N_SRC-1:0]   eligible, grant_oh;
    logic [2:0]         pick_hi, pick_lo, pick;
    logic               found_hi, found_lo;
    logic               pio_pending, push_attempt;
    logic               rd_req, wr_req, ev_pop;
    logic               fifo_wr_rdy, fifo_rd_vld;
    logic [31:0]        fifo_rd_dat, ev_word;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full;
    logic               unused_bits;

    assign unused_bits = ^{m_readdata, s_writedata};

    assign eligible = src_irq & enable_q;
    assign rd_req   = s_chipselect && s_read;
    assign wr_req   = s_chipselect && s_write;
    assign ev_pop   = rd_req && (s_address == 2'd1);
    assign ev_word  = {1'b1, 15'd0, seq_q, 5'd0, grant_q};
    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));

    // Descending scan: the last hit is the lowest index, preferring those at or after rr_ptr.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick_lo  = 3'(i);
                found_lo = 1'b1;
                if (3'(i) >= rr_ptr_q) begin
                    pick_hi  = 3'(i);
                    found_hi = 1'b1;
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    always_comb begin
        grant_oh    = '0;
        pio_pending = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            grant_oh[i] = (grant_q == 3'(i));
            if (grant_q == 3'(i)) begin
                pio_pending = m_readdata[32*i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        push_attempt = 1'b0;
        case (state_q)
            IDLE: begin
                if (found_lo) begin
                    grant_d = pick;
                    state_d = READ;
                end
            end
            READ:  state_d = WAIT;
            WAIT:  state_d = pio_pending ? CLEAR : IDLE;
            CLEAR: state_d = PUSH;
            PUSH: begin
                push_attempt = 1'b1;
                state_d      = IDLE;
                rr_ptr_d     = (grant_q == 3'(N_SRC - 1)) ? 3'd0 : grant_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are gated by reset so an aborted CLEAR never reaches the PIO.
    always_comb begin
        m_chipselect = '0;
        m_address    = 2'd0;
        m_write_n    = 1'b1;
        m_writedata  = 32'd0;
        if (!reset) begin
            if (state_q == READ) begin
                m_chipselect = grant_oh;
                m_address    = 2'd3;
            end else if (state_q == CLEAR) begin
                m_chipselect = grant_oh;
                m_address    = 2'd3;
                m_write_n    = 1'b0;
            end
        end
    end

    always_comb begin
        seq_d        = seq_q;
        ovf_d        = ovf_q;
        enable_d     = enable_q;
        s_readdata_d = 32'd0;
        if (push_attempt && fifo_wr_rdy) begin
            seq_d = seq_q + 8'd1;
        end
        if (wr_req && (s_address == 2'd2)) begin
            enable_d = s_writedata[N_SRC-1:0];
        end
        if (wr_req && (s_address == 2'd3) && s_writedata[8]) begin
            ovf_d = 1'b0;
        end
        if (push_attempt && !fifo_wr_rdy) begin
            ovf_d = 1'b1;
        end
        if (rd_req) begin
            case (s_address)
                2'd0: begin
                    s_readdata_d[0]   = fifo_rd_vld;
                    s_readdata_d[1]   = fifo_full;
                    s_readdata_d[6:2] = 5'(fifo_count);
                    s_readdata_d[8]   = ovf_q;
                end
                2'd1:    s_readdata_d = fifo_rd_vld ? fifo_rd_dat : 32'd0;
                2'd2:    s_readdata_d[N_SRC-1:0] = enable_q;
                default: s_readdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            seq_q        <= '0;
            ovf_q        <= 1'b0;
            enable_q     <= '0;
            s_readdata_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            seq_q        <= seq_d;
            ovf_q        <= ovf_d;
            enable_q     <= enable_d;
            s_readdata_q <= s_readdata_d;
        end
    end

    sync_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_ev_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (push_attempt),
        .wr_dat (ev_word),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (fifo_rd_vld),
        .rd_dat (fifo_rd_dat),
        .rd_rdy (ev_pop),
        .count  (fifo_count)
    );

    assign s_readdata = s_readdata_q;
    assign irq        = fifo_rd_vld;
endmodule
